// File: rtl/key_debouncer.sv
// Push-button conditioner: two-flop synchronizer plus press/release debounce FSM
// producing a clean level, one-cycle event pulses and a wrapping press counter.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       key_n,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HW = (LONG_CYCLES > 1)     ? $clog2(LONG_CYCLES)     : 1;
    localparam int unsigned RW = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        UP,
        CHK_DOWN,
        DOWN,
        CHK_UP
    } state_t;

    logic [1:0]    sync_q;
    logic          s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hcnt_q;
    logic [RW-1:0] rcnt_q;
    logic          long_done_q;
    logic          key_level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          repeat_q;
    logic [7:0]    press_count_q;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], ~key_n};
        end
    end

    assign s = sync_q[1];

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q       <= UP;
            cnt_q         <= '0;
            hcnt_q        <= '0;
            rcnt_q        <= '0;
            long_done_q   <= 1'b0;
            key_level_q   <= 1'b0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            press_count_q <= '0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            unique case (state_q)
                UP: begin
                    if (s) begin
                        state_q <= CHK_DOWN;
                        cnt_q   <= CW'(1);
                    end
                end
                CHK_DOWN: begin
                    if (!s) begin
                        state_q <= UP;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= DOWN;
                        cnt_q         <= '0;
                        press_q       <= 1'b1;
                        key_level_q   <= 1'b1;
                        press_count_q <= press_count_q + 8'd1;
                        hcnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DOWN: begin
                    // hold/repeat counters only advance while the key reads pressed
                    if (!s) begin
                        state_q <= CHK_UP;
                        cnt_q   <= CW'(1);
                    end else if (!long_done_q) begin
                        if (hcnt_q == HCNT_LAST) begin
                            long_q      <= 1'b1;
                            long_done_q <= 1'b1;
                            rcnt_q      <= '0;
                        end else begin
                            hcnt_q <= hcnt_q + HW'(1);
                        end
                    end else if (rcnt_q == RCNT_LAST) begin
                        repeat_q <= 1'b1;
                        rcnt_q   <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                end
                CHK_UP: begin
                    if (s) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= UP;
                        cnt_q       <= '0;
                        release_q   <= 1'b1;
                        key_level_q <= 1'b0;
                        long_done_q <= 1'b0;
                        hcnt_q      <= '0;
                        rcnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= UP;
                end
            endcase
        end
    end

    assign key_level     = key_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random bounce
// traffic, compared against an edge-counting reference of the debounce rules.
module tb_key_debouncer;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam int unsigned R = 8;

    logic       CLOCK_50 = 1'b0;
    logic       KEY0     = 1'b0;
    logic       key_n    = 1'b1;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic [7:0] press_count;

    int checks   = 0;
    int failures = 0;

    key_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .REPEAT_CYCLES  (R)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .KEY0         (KEY0),
        .key_n        (key_n),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .press_count  (press_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference: a level flips after D consecutive synchronized samples that
    // disagree with it; hold time counts pressed samples seen while settled down.
    bit         m_p1, m_p2, m_level, m_done;
    bit         m_press, m_rel, m_long, m_rep;
    int         m_run, m_hold, m_rcnt;
    logic [7:0] m_count;

    always @(posedge CLOCK_50 or negedge KEY0) begin
        bit seen;
        if (!KEY0) begin
            m_p1 = 0; m_p2 = 0; m_level = 0; m_done = 0;
            m_press = 0; m_rel = 0; m_long = 0; m_rep = 0;
            m_run = 0; m_hold = 0; m_rcnt = 0; m_count = 8'd0;
        end else begin
            seen = m_p2;
            m_p2 = m_p1;
            m_p1 = ~key_n;
            m_press = 0; m_rel = 0; m_long = 0; m_rep = 0;
            if (seen != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_run   = 0;
                    m_level = seen;
                    m_hold  = 0;
                    if (seen) begin
                        m_press = 1;
                        m_count = m_count + 8'd1;
                    end else begin
                        m_rel  = 1;
                        m_rcnt = 0;
                        m_done = 0;
                    end
                end
            end else begin
                if (m_level && m_run == 0) begin
                    if (!m_done) begin
                        m_hold++;
                        if (m_hold == L) begin
                            m_long = 1;
                            m_done = 1;
                            m_rcnt = 0;
                        end
                    end else begin
                        m_rcnt++;
                        if (m_rcnt == R) begin
                            m_rep  = 1;
                            m_rcnt = 0;
                        end
                    end
                end
                m_run = 0;
            end
        end
    end

    logic [12:0] obs, exp_v;
    assign obs   = {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse, press_count};
    assign exp_v = {m_level, m_press, m_rel, m_long, m_rep, m_count};

    task automatic tick(input logic kn);
        key_n = kn;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic apply_reset();
        #3 KEY0 = 1'b0;
        #2 KEY0 = 1'b1;
    endtask

    task automatic test_reset();
        KEY0  = 1'b0;
        key_n = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        if (obs !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", obs);
        end
        checks++;
        #4 KEY0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1);
            if (obs !== 13'd0) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d got=%h exp=0", i, obs);
            end
            checks++;
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 5; i++) begin
                tick(i < 3 ? 1'b0 : 1'b1);
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL bounce_model b=%0d i=%0d got=%h exp=%h", b, i, obs, exp_v);
                end
                checks++;
                pulses += int'(press_pulse) + int'(release_pulse) + int'(key_level);
            end
        end
        repeat (8) tick(1'b1);
        if (pulses != 0 || key_level !== 1'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL bounce_reject pulses=%0d level=%b count=%0d exp 0/0/0",
                     pulses, key_level, press_count);
        end
        checks++;
    endtask

    task automatic test_clean_press();
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0);
            if (press_pulse !== (i == D + 2) || key_level !== (i >= D + 2)) begin
                failures++;
                $display("FAIL clean_press cyc=%0d press=%b level=%b exp_press=%b",
                         i, press_pulse, key_level, i == D + 2);
            end
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL clean_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
            checks++;
        end
        if (press_count !== 8'd1) begin
            failures++;
            $display("FAIL clean_count got=%0d exp=1", press_count);
        end
        checks++;
    endtask

    task automatic test_release_glitch();
        for (int i = 0; i < 8; i++) begin
            tick(i < 2 ? 1'b1 : 1'b0);
            if (release_pulse !== 1'b0 || key_level !== 1'b1) begin
                failures++;
                $display("FAIL glitch_hold i=%0d rel=%b level=%b exp 0/1", i, release_pulse, key_level);
            end
            checks++;
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1);
            if (release_pulse !== (i == D + 2) || key_level !== (i < D + 2)) begin
                failures++;
                $display("FAIL release cyc=%0d rel=%b level=%b", i, release_pulse, key_level);
            end
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL release_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
            checks++;
        end
    endtask

    task automatic test_long_repeat();
        for (int i = 1; i <= D + 2; i++) tick(1'b0);
        if (press_pulse !== 1'b1) begin
            failures++;
            $display("FAIL long_press_start press=%b exp=1", press_pulse);
        end
        checks++;
        for (int j = 1; j <= 60; j++) begin
            tick(1'b0);
            if (long_pulse !== (j == L) ||
                repeat_pulse !== (j > L && (j - L) % R == 0)) begin
                failures++;
                $display("FAIL long_repeat j=%0d long=%b rep=%b", j, long_pulse, repeat_pulse);
            end
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL long_model j=%0d got=%h exp=%h", j, obs, exp_v);
            end
            checks++;
        end
        for (int k = 1; k <= 14; k++) begin
            tick(1'b1);
            if (repeat_pulse !== 1'b0 || long_pulse !== 1'b0 || release_pulse !== (k == D + 2)) begin
                failures++;
                $display("FAIL long_release k=%0d rep=%b long=%b rel=%b",
                         k, repeat_pulse, long_pulse, release_pulse);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b1;
        for (int r = 0; r < 60; r++) begin
            int len;
            lvl = ~lvl;
            len = (r % 5 == 0) ? int'($urandom_range(20, 50)) : int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                tick(lvl);
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL random_model run=%0d i=%0d got=%h exp=%h", r, i, obs, exp_v);
                end
                checks++;
            end
        end
        repeat (2 * D + 4) tick(1'b1);
    endtask

    task automatic test_wrap();
        int seen_press = 0;
        apply_reset();
        #1;
        if (obs !== 13'd0) begin
            failures++;
            $display("FAIL wrap_reset got=%h exp=0", obs);
        end
        checks++;
        for (int p = 1; p <= 257; p++) begin
            for (int i = 0; i < 2 * (D + 3); i++) begin
                tick(i < D + 3 ? 1'b0 : 1'b1);
                seen_press += int'(press_pulse);
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL wrap_model p=%0d i=%0d got=%h exp=%h", p, i, obs, exp_v);
                end
                checks++;
            end
            if (p == 256 && press_count !== 8'd0) begin
                failures++;
                $display("FAIL wrap_256 got=%0d exp=0", press_count);
            end
            if (p == 256) checks++;
        end
        if (press_count !== 8'd1 || seen_press != 257) begin
            failures++;
            $display("FAIL wrap_257 count=%0d pulses=%0d exp 1/257", press_count, seen_press);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 2 * (D + 3); i++) begin
                tick((i < D + 3 || p == 2) ? 1'b0 : 1'b1);
            end
        end
        if (press_count !== 8'd3 || key_level !== 1'b1) begin
            failures++;
            $display("FAIL async_setup count=%0d level=%b exp 3/1", press_count, key_level);
        end
        checks++;
        #3 KEY0 = 1'b0;
        #1;
        if (obs !== 13'd0) begin
            failures++;
            $display("FAIL async_reset_immediate got=%h exp=0", obs);
        end
        checks++;
        #2 KEY0 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0);
            if (press_pulse !== (i == D + 2) || release_pulse !== 1'b0 ||
                press_count !== ((i >= D + 2) ? 8'd1 : 8'd0)) begin
                failures++;
                $display("FAIL post_reset_press cyc=%0d press=%b rel=%b count=%0d",
                         i, press_pulse, release_pulse, press_count);
            end
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL post_reset_model cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_release_glitch();
        test_long_repeat();
        test_random();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Input-side conditioning block for the board's push buttons: synchronizes a raw active-low key to `CLOCK_50` and debounces it with a press/release state machine. It emits a clean level, single-cycle press, release, long-press and auto-repeat pulses, and an 8-bit press counter. It sits between a physical KEY pin and the LED/counter logic that consumes user events.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples required to accept a change (20 ms @ 50 MHz); must be ≥ 2.
- `LONG_CYCLES`, 50_000_000: held cycles in DOWN before `long_pulse` (1 s).
- `REPEAT_CYCLES`, 12_500_000: period of `repeat_pulse` after the long press (250 ms).
- `CLOCK_50`  in  1  system clock, 50 MHz; single clock domain.
- `KEY0`  in  1  reset, asynchronous, active-low.
- `key_n`  in  1  raw button, active-low, asynchronous to `CLOCK_50`.
- `key_level`  out  1  debounced state, 1 = pressed.
- `press_pulse`  out  1  one-cycle pulse on accepted press.
- `release_pulse`  out  1  one-cycle pulse on accepted release.
- `long_pulse`  out  1  one-cycle pulse when hold reaches `LONG_CYCLES`.
- `repeat_pulse`  out  1  one-cycle pulse every `REPEAT_CYCLES` after `long_pulse` while held.
- `press_count`  out  8  accepted presses, modulo 256.

## Operation
- Synchronizer: two flops sample `~key_n`. Their output `s` has 1 = pressed. Both reset to 0.
- States: UP, CHK_DOWN, DOWN, CHK_UP. Reset state is UP.
- UP: if `s`=1, go to CHK_DOWN and set `cnt`=1. Otherwise stay.
- CHK_DOWN: if `s`=0, return to UP and set `cnt`=0.
  - Else if `cnt`==DEBOUNCE_CYCLES-1, go to DOWN. Assert `press_pulse`, set `key_level`=1, increment `press_count` (255→0 wraps), and clear the hold counter `hcnt`.
  - Else increment `cnt`.
- DOWN: `hcnt` increments every cycle.
  - When `hcnt` reaches LONG_CYCLES-1: assert `long_pulse`, set the `long_done` flag, clear `rcnt`.
  - After `long_done`: `rcnt` increments. At REPEAT_CYCLES-1, assert `repeat_pulse` and set `rcnt`=0.
  - `hcnt` saturates once `long_done` is set.
  - If `s`=0, go to CHK_UP with `cnt`=1. Counting of `hcnt`/`rcnt` pauses on that edge.
- CHK_UP: `key_level` stays 1. `hcnt`/`rcnt` are frozen, and no long or repeat pulses are issued.
  - If `s`=1, return to DOWN and set `cnt`=0; hold counting resumes.
  - Else if `cnt`==DEBOUNCE_CYCLES-1, go to UP. Assert `release_pulse`, set `key_level`=0, clear `long_done`/`hcnt`/`rcnt`.
  - Else increment `cnt`.
- Counter widths use `$clog2` of the respective parameter. No arithmetic overflow is permitted except `press_count`.
- Reset asserted mid-operation: every register returns to its reset value immediately. No release pulse is generated.

## Timing
- Reset values: `key_level`=0, all pulses 0, `press_count`=0, state UP, all counters 0, synchronizer 0.
- All outputs are registered. Every pulse is exactly one cycle wide.
- Press latency:
  - Raw low sampled at edge N gives `s`=1 at edge N+1.
  - CHK_DOWN is entered at edge N+2.
  - `press_pulse` and `key_level` rise at edge N+1+DEBOUNCE_CYCLES, provided `key_n` stays low throughout.
- Release latency is symmetric: raw high sampled at edge M gives `release_pulse` and `key_level` fall at edge M+1+DEBOUNCE_CYCLES.
- Any bounce shorter than DEBOUNCE_CYCLES samples produces no output change and no pulse.
- `long_pulse` occurs LONG_CYCLES edges after `press_pulse`, excluding cycles spent in CHK_UP.
- The first `repeat_pulse` follows `long_pulse` by REPEAT_CYCLES edges, and repeats at that period.
- Pulses never overlap: press/release are exclusive by state, and long/repeat fire only in DOWN.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
- Clean press: `key_n` low sampled at edge 10 and held → `press_pulse` high for one cycle after edge 15; `key_level`=1; `press_count`=1.
- Bounce rejection: `key_n` low for 3 cycles, high for 2, repeated 5 times, then high → no pulses; `key_level`=0; `press_count`=0.
- Release with glitch: while DOWN, `key_n` high for 2 cycles then low → stays DOWN with no `release_pulse`. Then `key_n` high and held → `release_pulse` at +5 edges; `key_level`=0.
- Long/repeat: hold 60 cycles after `press_pulse` → `long_pulse` 20 edges after `press_pulse`; `repeat_pulse` at +28, +36, +44, +52, +60. Release → `release_pulse`, and no further repeats.
- Counter wrap: 256 clean presses → `press_count` returns to 0; 257th press → 1.
- Async reset mid-hold: pulse `KEY0` low while DOWN with `press_count`=3 → all outputs 0 immediately with no clock edge needed. After reset, `key_n` still held low → new `press_pulse` 5 edges after the first post-reset sample.
